// File: rtl/top.sv
// "Sang dan" LED bar sequencer: the bar fills from LED0 up to the top LED, then
// drains from the top back down, advancing one LED per CLK_DIV system clocks.
module top #(
    parameter int unsigned CLK_DIV = 25_000_000,
    parameter int unsigned LED_W   = 8
) (
    input  logic             clki,
    input  logic             rs,
    output logic [LED_W-1:0] led
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        FILL  = 2'b01,
        DRAIN = 2'b10
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             step_c;

    // The step is taken on the same edge the prescaler wraps, so the first LED
    // lights on the CLK_DIV-th edge after reset release.
    assign step_c = (count == CNT_MAX);

    // Prescaler: counts 0..CLK_DIV-1 and wraps.
    always_ff @(posedge clki or negedge rs) begin
        if (!rs) begin
            count <= '0;
        end else if (step_c) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // Fill/drain sequencer. Full and empty codes are detected from the bits that
    // survive the shift, so each end code is shown for exactly one step.
    always_ff @(posedge clki or negedge rs) begin
        if (!rs) begin
            state <= FILL;
            led   <= '0;
        end else if (step_c) begin
            case (state)
                FILL: begin
                    led <= {led[LED_W-2:0], 1'b1};
                    if (led[LED_W-2:0] == '1) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    led <= {1'b0, led[LED_W-1:1]};
                    if (led[LED_W-1:1] == '0) begin
                        state <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                    led   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_top.sv
// Directed bench for the LED bar sequencer: one instance at CLK_DIV=4 and one at
// CLK_DIV=1, both compared every clock against a hand-written period table.
module tb_top;

    logic       clki;
    logic       rs;
    logic       rs1;
    logic [7:0] led4;
    logic [7:0] led1;

    top #(.CLK_DIV(4), .LED_W(8)) dut4 (.clki(clki), .rs(rs),  .led(led4));
    top #(.CLK_DIV(1), .LED_W(8)) dut1 (.clki(clki), .rs(rs1), .led(led1));

    initial clki = 1'b0;
    always #10 clki = ~clki;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] tbl [16];
    int         cyc;
    int         idx;
    int         idx1;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clki);
        #1;
    endtask

    // Advance n clocks; every clock the CLK_DIV=4 bar must hold or step to the next
    // table entry on every 4th edge, and the CLK_DIV=1 bar steps on every edge.
    task automatic run(input int n, input bit chk1);
        for (int i = 0; i < n; i++) begin
            tick();
            cyc++;
            if (cyc % 4 == 0) idx = (idx + 1) % 16;
            check("div4_seq", led4, tbl[idx]);
            check("div4_legal", led4 & (led4 + 8'd1), 8'h00);
            if (chk1) begin
                idx1 = (idx1 + 1) % 16;
                check("div1_seq", led1, tbl[idx1]);
            end
        end
    endtask

    initial begin
        tbl = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};
        cyc  = 0;
        idx  = 0;
        idx1 = 0;
        rs   = 1'b0;
        rs1  = 1'b0;

        // Held reset
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_div4", led4, 8'h00);
            check("rst_div1", led1, 8'h00);
        end

        // Release between edges, then fill, drain, wrap and a long run
        @(negedge clki);
        rs  = 1'b1;
        rs1 = 1'b1;
        run(704, 1'b1);

        // Walk to 1F, then reset asynchronously between edges
        for (int i = 0; i < 64 && tbl[idx] != 8'h1F; i++) run(1, 1'b1);
        check("reach_1f", led4, 8'h1F);
        @(negedge clki);
        #3;
        rs = 1'b0;
        #1;
        check("async_rst", led4, 8'h00);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_hold", led4, 8'h00);
        end

        // Restart from FILL with a full prescaler delay
        @(negedge clki);
        rs  = 1'b1;
        cyc = 0;
        idx = 0;
        run(40, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
